// File: rtl/spi_xfer_sequencer_if.sv
// spi_xfer_sequencer_if
// Control/status bundle between the APB SPI register block and the
// transfer sequencer.
//   master modport : register-side driver (mode, master enable, request,
//                    divisor, optional abort); observes ss/tip/xfer_en and
//                    the completion/overrun pulses.
//   slave modport  : the sequencer itself.
// The abort signal exists only when SPI_SEQ_ABORT_EN is defined.
interface spi_xfer_sequencer_if;
    logic [1:0] spi_mode;
    logic       spiswai;
    logic       mstr;
    logic       send_data;
    logic [7:0] BaudRateDivisor;
`ifdef SPI_SEQ_ABORT_EN
    logic       abort;
`endif
    logic       ss;
    logic       tip;
    logic       xfer_en;
    logic       receive_data;
    logic       overrun;

`ifdef SPI_SEQ_ABORT_EN
    modport master (output spi_mode, spiswai, mstr, send_data, BaudRateDivisor, abort,
                    input  ss, tip, xfer_en, receive_data, overrun);
    modport slave  (input  spi_mode, spiswai, mstr, send_data, BaudRateDivisor, abort,
                    output ss, tip, xfer_en, receive_data, overrun);
`else
    modport master (output spi_mode, spiswai, mstr, send_data, BaudRateDivisor,
                    input  ss, tip, xfer_en, receive_data, overrun);
    modport slave  (input  spi_mode, spiswai, mstr, send_data, BaudRateDivisor,
                    output ss, tip, xfer_en, receive_data, overrun);
`endif
endinterface

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
// Frames a one-cycle send_data request into an SPI transfer: pulls ss low
// (which also enables the baud generator), times setup, data phase and
// hold, and reports completion. Holds one queued request and flags
// overrun when a further request arrives. Freezes in stop mode and in wait
// mode with spiswai set.
// Ports:
//   PCLK     : system clock, rising edge
//   PRESETn  : asynchronous active-low reset
//   bus      : spi_xfer_sequencer_if.slave (spi_mode, spiswai, mstr,
//              send_data, BaudRateDivisor in; ss, tip, xfer_en,
//              receive_data, overrun out; all outputs registered)
// Optional: define SPI_SEQ_ABORT_EN to add bus.abort, which returns the
// sequencer to IDLE and discards any queued request.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ss high; waits for send_data or a queued request
// S_SETUP | ss low; SETUP_CYCLES before the first SCLK window
// S_XFER  | xfer_en high; div*DATA_BITS cycles of data phase
// S_HOLD  | receive_data in first cycle; HOLD_CYCLES before ss rises
module spi_xfer_sequencer #(
    parameter int DATA_BITS    = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    spi_xfer_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [12:0] BITS_W     = 13'(DATA_BITS);
    localparam logic [12:0] SETUP_LOAD = 13'(SETUP_CYCLES - 1);
    localparam logic [12:0] HOLD_LOAD  = 13'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        ss_q, tip_q, xfer_en_q, rx_q, ovr_q;
    logic        rx_d, ovr_d;
    logic        active;
    logic        abort_req;
    logic [12:0] div_w;
    logic [12:0] target_w;

    assign active = (bus.spi_mode == 2'b00) | ((bus.spi_mode == 2'b01) & ~bus.spiswai);

`ifdef SPI_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Divisors below 2 cannot form an SCLK period, so they are clamped.
    assign div_w    = (bus.BaudRateDivisor < 8'd2) ? 13'd2 : {5'd0, bus.BaudRateDivisor};
    assign target_w = div_w * BITS_W;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        rx_d      = 1'b0;
        ovr_d     = 1'b0;

        // Request queue. In IDLE while active the request starts directly
        // below instead of being queued.
        if (!bus.mstr) begin
            pending_d = 1'b0;
        end else if (bus.send_data) begin
            if (state_q == S_IDLE) begin
                if (!active) pending_d = 1'b1;
            end else if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                ovr_d = active;
            end
        end

        // Counters are loaded with length-1 and the phase ends at zero.
        if (active) begin
            case (state_q)
                S_IDLE: begin
                    if ((bus.send_data | pending_q) & bus.mstr) begin
                        state_d   = S_SETUP;
                        cnt_d     = SETUP_LOAD;
                        pending_d = 1'b0;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 13'd0) begin
                        state_d = S_XFER;
                        cnt_d   = target_w - 13'd1;
                    end else begin
                        cnt_d = cnt_q - 13'd1;
                    end
                end
                S_XFER: begin
                    if (cnt_q == 13'd0) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                        rx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 13'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == 13'd0) begin
                        state_d = S_IDLE;
                        cnt_d   = 13'd0;
                    end else begin
                        cnt_d = cnt_q - 13'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 13'd0;
                end
            endcase
        end

        // Abort outranks everything, including a same-cycle request.
        if (abort_req) begin
            state_d   = S_IDLE;
            cnt_d     = 13'd0;
            pending_d = 1'b0;
            rx_d      = 1'b0;
            ovr_d     = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 13'd0;
            pending_q <= 1'b0;
            ss_q      <= 1'b1;
            tip_q     <= 1'b0;
            xfer_en_q <= 1'b0;
            rx_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ss_q      <= (state_d == S_IDLE);
            tip_q     <= (state_d != S_IDLE);
            xfer_en_q <= (state_d == S_XFER);
            rx_q      <= rx_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.ss           = ss_q;
    assign bus.tip          = tip_q;
    assign bus.xfer_en      = xfer_en_q;
    assign bus.receive_data = rx_q;
    assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Testbench for spi_xfer_sequencer: directed timing scenarios plus a
// randomized run, every cycle compared against a frame-position model.
module tb_spi_xfer_sequencer;
    localparam int S  = 2;
    localparam int H  = 2;
    localparam int DB = 8;

    logic PCLK;
    logic PRESETn;
    spi_xfer_sequencer_if bus();

    spi_xfer_sequencer dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: position within the current frame (1-based,
    // advancing once per active cycle) plus a queued-request flag.
    bit m_in;
    int m_pos;
    int m_T;
    bit m_pend;
    bit e_ss, e_tip, e_xf, e_rx, e_ovr;

    // Recorder of observed DUT activity, relative to cyc.
    int rx_n, rx_first, rx_last, xf_n, xf_first, xf_last;
    int lo_n, lo_first, lo_last, ovr_n, ovr_first, gap;
    logic prev_ss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_pos = 0; m_T = 0; m_pend = 0;
        e_ss = 1; e_tip = 0; e_xf = 0; e_rx = 0; e_ovr = 0;
    endtask

    task automatic model_step();
        bit act, snd, ab;
        int dv;
        e_rx = 0;
        e_ovr = 0;
        if (!PRESETn) begin
            model_reset();
        end else begin
            act = (bus.spi_mode == 2'b00) || (bus.spi_mode == 2'b01 && !bus.spiswai);
            snd = bus.send_data;
`ifdef SPI_SEQ_ABORT_EN
            ab = bus.abort;
`else
            ab = 0;
`endif
            if (ab) begin
                m_in = 0; m_pos = 0; m_pend = 0;
            end else begin
                if (!bus.mstr) m_pend = 0;
                else if (snd) begin
                    if (!m_in) begin
                        if (!act) m_pend = 1;
                    end else if (!m_pend) m_pend = 1;
                    else if (act) e_ovr = 1;
                end
                if (act) begin
                    if (!m_in) begin
                        if ((snd || m_pend) && bus.mstr) begin
                            m_in = 1; m_pos = 1; m_pend = 0;
                        end
                    end else begin
                        if (m_pos == S) begin
                            dv = int'(bus.BaudRateDivisor);
                            if (dv < 2) dv = 2;
                            m_T = dv * DB;
                        end
                        m_pos++;
                        if (m_pos == S + m_T + 1) e_rx = 1;
                        if (m_pos > S + m_T + H) begin
                            m_in = 0; m_pos = 0;
                        end
                    end
                end
            end
            e_ss  = !m_in;
            e_tip = m_in;
            e_xf  = m_in && (m_pos > S) && (m_pos <= S + m_T);
        end
    endtask

    task automatic clear_rec();
        rx_n = 0; rx_first = -1; rx_last = -1;
        xf_n = 0; xf_first = -1; xf_last = -1;
        lo_n = 0; lo_first = -1; lo_last = -1;
        ovr_n = 0; ovr_first = -1; gap = -1;
        prev_ss = 1'b1;
    endtask

    task automatic tick();
        @(posedge PCLK);
        model_step();
        cyc++;
        @(negedge PCLK);
        chk("ss", 32'(bus.ss), 32'(e_ss));
        chk("tip", 32'(bus.tip), 32'(e_tip));
        chk("xfer_en", 32'(bus.xfer_en), 32'(e_xf));
        chk("receive_data", 32'(bus.receive_data), 32'(e_rx));
        chk("overrun", 32'(bus.overrun), 32'(e_ovr));
        if (bus.receive_data === 1'b1) begin
            rx_n++; rx_last = cyc;
            if (rx_first < 0) rx_first = cyc;
        end
        if (bus.xfer_en === 1'b1) begin
            xf_n++; xf_last = cyc;
            if (xf_first < 0) xf_first = cyc;
        end
        if (bus.ss === 1'b0) begin
            if (lo_n > 0 && prev_ss === 1'b1) gap = cyc - lo_last - 1;
            lo_n++; lo_last = cyc;
            if (lo_first < 0) lo_first = cyc;
        end
        if (bus.overrun === 1'b1) begin
            ovr_n++;
            if (ovr_first < 0) ovr_first = cyc;
        end
        prev_ss = bus.ss;
    endtask

    task automatic start_and_run(input int last);
        clear_rec();
        cyc = 0;
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        while (cyc < last) tick();
    endtask

    initial begin
        PRESETn = 1'b0;
        bus.spi_mode = 2'b00;
        bus.spiswai = 1'b0;
        bus.mstr = 1'b1;
        bus.send_data = 1'b0;
        bus.BaudRateDivisor = 8'd16;
`ifdef SPI_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        model_reset();
        clear_rec();
        tick(); tick();
        PRESETn = 1'b1;
        repeat (3) tick();

        // single transfer, divisor 16
        start_and_run(140);
        chk("s1_ss_first", lo_first, 1);
        chk("s1_ss_last", lo_last, 132);
        chk("s1_ss_count", lo_n, 132);
        chk("s1_xf_first", xf_first, 3);
        chk("s1_xf_last", xf_last, 130);
        chk("s1_rx_cycle", rx_first, 131);
        chk("s1_rx_count", rx_n, 1);

        // back-to-back, divisor 4, one request queued and one dropped
        bus.BaudRateDivisor = 8'd4;
        clear_rec();
        cyc = 0;
        while (cyc < 80) begin
            bus.send_data = (cyc == 0 || cyc == 10 || cyc == 12);
            tick();
        end
        bus.send_data = 1'b0;
        chk("b2b_ovr_count", ovr_n, 1);
        chk("b2b_ovr_cycle", ovr_first, 13);
        chk("b2b_rx_count", rx_n, 2);
        chk("b2b_rx_first", rx_first, 35);
        chk("b2b_rx_last", rx_last, 72);
        chk("b2b_ss_gap", gap, 1);

        // wait-mode freeze of 20 cycles mid-XFER
        bus.BaudRateDivisor = 8'd16;
        bus.spiswai = 1'b1;
        clear_rec();
        cyc = 0;
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        while (cyc < 170) begin
            bus.spi_mode = (cyc >= 50 && cyc < 70) ? 2'b01 : 2'b00;
            tick();
        end
        bus.spi_mode = 2'b00;
        bus.spiswai = 1'b0;
        chk("frz_rx_cycle", rx_first, 151);
        chk("frz_ss_first", lo_first, 1);
        chk("frz_ss_last", lo_last, 152);
        chk("frz_ss_count", lo_n, 152);

        // divisor clamping and extremes
        bus.BaudRateDivisor = 8'd0;
        start_and_run(30);
        chk("div0_xf_len", xf_n, 16);
        bus.BaudRateDivisor = 8'd255;
        start_and_run(2050);
        chk("div255_xf_len", xf_n, 2040);
        chk("div255_rx_cycle", rx_first, 2043);

        // divisor change mid-XFER leaves current length alone
        bus.BaudRateDivisor = 8'd16;
        clear_rec();
        cyc = 0;
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        while (cyc < 140) begin
            if (cyc == 20) bus.BaudRateDivisor = 8'd3;
            tick();
        end
        chk("divchg_xf_len", xf_n, 128);
        start_and_run(40);
        chk("divchg_next_xf_len", xf_n, 24);

        // asynchronous reset mid-XFER
        bus.BaudRateDivisor = 8'd16;
        start_and_run(40);
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_ss_async", 32'(bus.ss), 1);
        chk("rst_tip_async", 32'(bus.tip), 0);
        chk("rst_xf_async", 32'(bus.xfer_en), 0);
        model_reset();
        tick();
        PRESETn = 1'b1;
        while (cyc < 160) tick();
        chk("rst_no_rx", rx_n, 0);

        // master disabled: request ignored
        bus.mstr = 1'b0;
        start_and_run(20);
        chk("mstr0_no_frame", lo_n, 0);

        // master dropped with a queued request: current frame finishes only
        bus.mstr = 1'b1;
        bus.BaudRateDivisor = 8'd2;
        clear_rec();
        cyc = 0;
        while (cyc < 45) begin
            bus.send_data = (cyc == 0 || cyc == 5);
            if (cyc == 6) bus.mstr = 1'b0;
            tick();
        end
        bus.send_data = 1'b0;
        bus.mstr = 1'b1;
        chk("mstr0_pend_rx", rx_n, 1);
        chk("mstr0_pend_ss_last", lo_last, 20);

`ifdef SPI_SEQ_ABORT_EN
        // abort at cycle 50 of a divisor-16 transfer, then a normal frame
        bus.BaudRateDivisor = 8'd16;
        clear_rec();
        cyc = 0;
        bus.send_data = 1'b1;
        tick();
        bus.send_data = 1'b0;
        while (cyc < 140) begin
            bus.abort = (cyc == 50);
            tick();
        end
        bus.abort = 1'b0;
        chk("abort_ss_last", lo_last, 50);
        chk("abort_no_rx", rx_n, 0);
        start_and_run(140);
        chk("abort_next_ss_count", lo_n, 132);
        chk("abort_next_rx", rx_first, 131);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            bus.send_data = ($urandom_range(7) == 0);
            r = int'($urandom_range(15));
            bus.spi_mode = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00;
            bus.spiswai = $urandom_range(1) == 1;
            bus.mstr = ($urandom_range(31) != 0);
            bus.BaudRateDivisor = 8'($urandom_range(5));
`ifdef SPI_SEQ_ABORT_EN
            bus.abort = ($urandom_range(63) == 0);
`endif
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
